// File: rtl/id_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_pkg
// Purpose : Shared definitions for the MIPS decode stage: datapath widths,
//           opcode constants, ID/EX control-vector bit positions and the
//           opcode-to-control decode function.
// Ports   : none (package)
// Config  : none here; WB_BYPASS_EN is consumed by id_regfile.
// -----------------------------------------------------------------------------
package id_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = 5;
    localparam int CTRL_W   = 9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // Control vector layout:
    // {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[1:0]}
    localparam int CTRL_REG_WRITE  = 8;
    localparam int CTRL_MEM_TO_REG = 7;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_ALU_SRC    = 3;
    localparam int CTRL_REG_DST    = 2;
    localparam int CTRL_ALU_OP_HI  = 1;
    localparam int CTRL_ALU_OP_LO  = 0;

    function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [5:0] opcode);
        logic [CTRL_W-1:0] ctrl;
        ctrl = '0;
        case (opcode)
            OP_RTYPE: ctrl = 9'b1_0_0_0_0_0_1_10;
            OP_LW:    ctrl = 9'b1_1_1_0_0_1_0_00;
            OP_SW:    ctrl = 9'b0_0_0_1_0_1_0_00;
            OP_BEQ:   ctrl = 9'b0_0_0_0_1_0_0_01;
            OP_ADDI:  ctrl = 9'b1_0_0_0_0_1_0_00;
            default:  ctrl = '0;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// -----------------------------------------------------------------------------
// id_stage_if
// Purpose : Bundles the decode-stage bus: IF/ID inputs, EX/MEM flush, WB write
//           port, the stall line back to IF and the ID/EX register outputs.
// Signals : instr_in, pc4_in, ex_flush, wb_we, wb_addr, wb_data   (into ID)
//           hazard, id_ex_pc4, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
//           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_funct, id_ex_ctrl (out of ID)
// Modports: slave  - the decode stage itself
//           master - the surrounding pipeline (IF/EX/WB) or a test harness
// Flow control: there is no valid/ready pair. hazard is the only back-pressure:
//           while it is high, IF must hold PC and IF/ID so the same instr_in
//           is presented again next cycle; ID/EX receives a bubble meanwhile.
// -----------------------------------------------------------------------------
interface id_stage_if;
    import id_stage_pkg::*;

    logic [DATA_W-1:0] instr_in;
    logic [DATA_W-1:0] pc4_in;
    logic              ex_flush;
    logic              wb_we;
    logic [RF_AW-1:0]  wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              hazard;
    logic [DATA_W-1:0] id_ex_pc4;
    logic [DATA_W-1:0] id_ex_rs_data;
    logic [DATA_W-1:0] id_ex_rt_data;
    logic [DATA_W-1:0] id_ex_imm;
    logic [RF_AW-1:0]  id_ex_rs;
    logic [RF_AW-1:0]  id_ex_rt;
    logic [RF_AW-1:0]  id_ex_rd;
    logic [5:0]        id_ex_funct;
    logic [CTRL_W-1:0] id_ex_ctrl;

    modport slave (
        input  instr_in, pc4_in, ex_flush, wb_we, wb_addr, wb_data,
        output hazard, id_ex_pc4, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
               id_ex_rs, id_ex_rt, id_ex_rd, id_ex_funct, id_ex_ctrl
    );

    modport master (
        output instr_in, pc4_in, ex_flush, wb_we, wb_addr, wb_data,
        input  hazard, id_ex_pc4, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
               id_ex_rs, id_ex_rt, id_ex_rd, id_ex_funct, id_ex_ctrl
    );

endinterface

// File: rtl/id_stage_regfile.sv
// -----------------------------------------------------------------------------
// id_regfile
// Purpose : 32 x 32-bit GPR file, two asynchronous read ports, one synchronous
//           write port. $0 always reads 0 and ignores writes. All registers
//           clear on reset.
// Ports   : clk, reset (sync, active-high)
//           rs_addr_i, rt_addr_i -> rs_data_o, rt_data_o (combinational)
//           we_i, waddr_i, wdata_i (write on posedge)
// Config  : WB_BYPASS_EN defined -> a same-cycle write is forwarded to the
//           read ports (write-first). Undefined -> reads see pre-write data.
// -----------------------------------------------------------------------------
module id_regfile
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [RF_AW-1:0]  rs_addr_i,
    input  logic [RF_AW-1:0]  rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    input  logic              we_i,
    input  logic [RF_AW-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [RF_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [RF_AW-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (addr != '0) begin
`ifdef WB_BYPASS_EN
            if (we_i && (waddr_i == addr)) begin
                val = wdata_i;
            end else begin
                val = regs_q[addr];
            end
`else
            val = regs_q[addr];
`endif
        end
        return val;
    endfunction

    always_comb begin
        rs_data_o = read_port(rs_addr_i);
        rt_data_o = read_port(rt_addr_i);
    end

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// Purpose : MIPS instruction-decode stage. Decodes control from the opcode,
//           reads the GPR file, detects load-use hazards (stall request to IF)
//           and owns the ID/EX pipeline register.
// Ports   : clk          - clock, rising edge
//           reset        - synchronous, active-high
//           bus (slave)  - id_stage_if: IF/ID inputs, ex_flush, WB write port,
//                          hazard (combinational) and registered id_ex_* fields
// Config  : WB_BYPASS_EN (see id_regfile) selects write-first register reads.
// ID/EX priority: reset > ex_flush > hazard > capture. The first three all
//           load an all-zero bubble, so they collapse into one select.
// -----------------------------------------------------------------------------
module id_stage
    import id_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    id_stage_if.slave  bus
);

    logic [5:0]        opcode;
    logic [RF_AW-1:0]  rs_f, rt_f, rd_f;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic [CTRL_W-1:0] ctrl;
    logic              hazard;
    logic              bubble;

    logic [DATA_W-1:0] pc4_q, rs_data_q, rt_data_q, imm_q;
    logic [DATA_W-1:0] pc4_d, rs_data_d, rt_data_d, imm_d;
    logic [RF_AW-1:0]  rs_q, rt_q, rd_q, rs_d, rt_d, rd_d;
    logic [5:0]        funct_q, funct_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    assign opcode = bus.instr_in[31:26];
    assign rs_f   = bus.instr_in[25:21];
    assign rt_f   = bus.instr_in[20:16];
    assign rd_f   = bus.instr_in[15:11];
    assign ctrl   = decode_ctrl(opcode);

    id_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rs_addr_i (rs_f),
        .rt_addr_i (rt_f),
        .rs_data_o (rs_data),
        .rt_data_o (rt_data),
        .we_i      (bus.wb_we),
        .waddr_i   (bus.wb_addr),
        .wdata_i   (bus.wb_data)
    );

    // A load in EX whose destination feeds this instruction stalls one cycle.
    // A taken branch kills the ID instruction anyway, so the stall is dropped
    // to let IF follow the branch target.
    assign hazard = ctrl_q[CTRL_MEM_READ] && (rt_q != '0) &&
                    ((rt_q == rs_f) || (rt_q == rt_f)) && !bus.ex_flush;

    assign bubble = reset || bus.ex_flush || hazard;

    always_comb begin
        pc4_d     = bus.pc4_in;
        rs_data_d = rs_data;
        rt_data_d = rt_data;
        imm_d     = {{16{bus.instr_in[15]}}, bus.instr_in[15:0]};
        rs_d      = rs_f;
        rt_d      = rt_f;
        rd_d      = rd_f;
        funct_d   = bus.instr_in[5:0];
        ctrl_d    = ctrl;
        if (bubble) begin
            pc4_d     = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            funct_d   = '0;
            ctrl_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        pc4_q     <= pc4_d;
        rs_data_q <= rs_data_d;
        rt_data_q <= rt_data_d;
        imm_q     <= imm_d;
        rs_q      <= rs_d;
        rt_q      <= rt_d;
        rd_q      <= rd_d;
        funct_q   <= funct_d;
        ctrl_q    <= ctrl_d;
    end

    assign bus.hazard        = hazard;
    assign bus.id_ex_pc4     = pc4_q;
    assign bus.id_ex_rs_data = rs_data_q;
    assign bus.id_ex_rt_data = rt_data_q;
    assign bus.id_ex_imm     = imm_q;
    assign bus.id_ex_rs      = rs_q;
    assign bus.id_ex_rt      = rt_q;
    assign bus.id_ex_rd      = rd_q;
    assign bus.id_ex_funct   = funct_q;
    assign bus.id_ex_ctrl    = ctrl_q;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
// Purpose : Directed self-checking bench for id_stage. Inputs change 1 ns
//           after a rising edge; outputs are sampled there too, away from
//           the active edge.
// -----------------------------------------------------------------------------
module tb_id_stage;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [8:0] C_RTYPE = 9'b100000110;
    localparam logic [8:0] C_LW    = 9'b111001000;
    localparam logic [8:0] C_SW    = 9'b000101000;
    localparam logic [8:0] C_BEQ   = 9'b000010001;
    localparam logic [8:0] C_ADDI  = 9'b100001000;

    localparam logic [31:0] I_ADD_8_9_10   = 32'h012A4020;
    localparam logic [31:0] I_LW_8_4_9     = 32'h8D280004;
    localparam logic [31:0] I_ADD_10_8_11  = 32'h010B5020;
    localparam logic [31:0] I_LW_0_0_1     = 32'h8C200000;
    localparam logic [31:0] I_ADD_2_0_3    = 32'h00031020;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.instr_in = 32'h0;
        bus.pc4_in   = 32'h0;
        bus.ex_flush = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_addr  = 5'd0;
        bus.wb_data  = 32'h0;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        bus.instr_in = 32'h0;
        bus.wb_we    = 1'b1;
        bus.wb_addr  = addr;
        bus.wb_data  = data;
        step();
        bus.wb_we    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        bus.instr_in = I_ADD_8_9_10;
        bus.pc4_in   = 32'h44;
        step();
        step();
        n_checks++;
        if (bus.id_ex_ctrl !== 9'h0) begin
            n_fail++; $display("FAIL reset_ctrl got=%b exp=%b", bus.id_ex_ctrl, 9'h0);
        end
        n_checks++;
        if (bus.id_ex_pc4 !== 32'h0 || bus.id_ex_imm !== 32'h0 || bus.id_ex_rd !== 5'd0) begin
            n_fail++; $display("FAIL reset_fields got pc4=%h imm=%h rd=%0d exp=0", bus.id_ex_pc4, bus.id_ex_imm, bus.id_ex_rd);
        end
        n_checks++;
        if (bus.hazard !== 1'b0) begin
            n_fail++; $display("FAIL reset_hazard got=%b exp=0", bus.hazard);
        end
        reset = 1'b0;
        drive_idle();
        // GPR must be cleared by a later reset
        write_reg(5'd5, 32'h0000_0055);
        bus.instr_in = 32'h00A00020;   // add $0,$5,$0
        step();
        n_checks++;
        if (bus.id_ex_rs_data !== 32'h55) begin
            n_fail++; $display("FAIL gpr_write got=%h exp=%h", bus.id_ex_rs_data, 32'h55);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (bus.id_ex_rs_data !== 32'h0) begin
            n_fail++; $display("FAIL gpr_reset_clear got=%h exp=0", bus.id_ex_rs_data);
        end
    endtask

    task automatic test_add();
        drive_idle();
        write_reg(5'd9, 32'd5);
        write_reg(5'd10, 32'd7);
        bus.instr_in = I_ADD_8_9_10;
        bus.pc4_in   = 32'h100;
        step();
        n_checks++;
        if (bus.id_ex_rs_data !== 32'd5 || bus.id_ex_rt_data !== 32'd7) begin
            n_fail++; $display("FAIL add_operands got rs=%h rt=%h exp rs=5 rt=7", bus.id_ex_rs_data, bus.id_ex_rt_data);
        end
        n_checks++;
        if (bus.id_ex_ctrl !== C_RTYPE) begin
            n_fail++; $display("FAIL add_ctrl got=%b exp=%b", bus.id_ex_ctrl, C_RTYPE);
        end
        n_checks++;
        if (bus.id_ex_rs !== 5'd9 || bus.id_ex_rt !== 5'd10 || bus.id_ex_rd !== 5'd8 || bus.id_ex_funct !== 6'h20) begin
            n_fail++; $display("FAIL add_fields got rs=%0d rt=%0d rd=%0d fn=%h exp 9 10 8 20",
                               bus.id_ex_rs, bus.id_ex_rt, bus.id_ex_rd, bus.id_ex_funct);
        end
        n_checks++;
        if (bus.id_ex_imm !== 32'h0000_4020 || bus.id_ex_pc4 !== 32'h100) begin
            n_fail++; $display("FAIL add_imm_pc4 got imm=%h pc4=%h exp 00004020 00000100", bus.id_ex_imm, bus.id_ex_pc4);
        end
    endtask

    task automatic test_load_use();
        drive_idle();
        bus.instr_in = I_LW_8_4_9;
        step();
        bus.instr_in = I_ADD_10_8_11;
        #1;
        n_checks++;
        if (bus.hazard !== 1'b1) begin
            n_fail++; $display("FAIL loaduse_hazard_on got=%b exp=1", bus.hazard);
        end
        n_checks++;
        if (bus.id_ex_ctrl !== C_LW || bus.id_ex_imm !== 32'h4) begin
            n_fail++; $display("FAIL lw_capture got ctrl=%b imm=%h exp %b 4", bus.id_ex_ctrl, bus.id_ex_imm, C_LW);
        end
        step();   // IF holds the add; ID/EX gets a bubble
        n_checks++;
        if (bus.hazard !== 1'b0 || bus.id_ex_ctrl !== 9'h0 || bus.id_ex_rs !== 5'd0) begin
            n_fail++; $display("FAIL loaduse_bubble got hz=%b ctrl=%b rs=%0d exp 0 0 0", bus.hazard, bus.id_ex_ctrl, bus.id_ex_rs);
        end
        step();
        n_checks++;
        if (bus.id_ex_ctrl !== C_RTYPE || bus.id_ex_rs !== 5'd8 || bus.id_ex_rd !== 5'd10) begin
            n_fail++; $display("FAIL loaduse_resume got ctrl=%b rs=%0d rd=%0d exp %b 8 10", bus.id_ex_ctrl, bus.id_ex_rs, bus.id_ex_rd, C_RTYPE);
        end
    endtask

    task automatic test_load_zero();
        drive_idle();
        bus.instr_in = I_LW_0_0_1;
        step();
        bus.instr_in = I_ADD_2_0_3;
        #1;
        n_checks++;
        if (bus.hazard !== 1'b0) begin
            n_fail++; $display("FAIL lw_zero_hazard got=%b exp=0", bus.hazard);
        end
        step();
        n_checks++;
        if (bus.id_ex_ctrl !== C_RTYPE || bus.id_ex_rd !== 5'd2) begin
            n_fail++; $display("FAIL lw_zero_capture got ctrl=%b rd=%0d exp %b 2", bus.id_ex_ctrl, bus.id_ex_rd, C_RTYPE);
        end
    endtask

    task automatic test_flush();
        drive_idle();
        bus.instr_in = I_LW_8_4_9;
        step();
        bus.instr_in = I_ADD_10_8_11;
        bus.pc4_in   = 32'h200;
        bus.ex_flush = 1'b1;
        #1;
        n_checks++;
        if (bus.hazard !== 1'b0) begin
            n_fail++; $display("FAIL flush_hazard got=%b exp=0", bus.hazard);
        end
        step();
        n_checks++;
        if (bus.id_ex_ctrl !== 9'h0 || bus.id_ex_pc4 !== 32'h0) begin
            n_fail++; $display("FAIL flush_bubble got ctrl=%b pc4=%h exp 0 0", bus.id_ex_ctrl, bus.id_ex_pc4);
        end
        // flush with no hazard pending still kills the ID instruction
        bus.instr_in = 32'h2043FFFF;
        step();
        n_checks++;
        if (bus.id_ex_ctrl !== 9'h0 || bus.id_ex_imm !== 32'h0) begin
            n_fail++; $display("FAIL flush_plain got ctrl=%b imm=%h exp 0 0", bus.id_ex_ctrl, bus.id_ex_imm);
        end
        bus.ex_flush = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        drive_idle();
        bus.instr_in = I_LW_8_4_9;
        step();
        bus.instr_in = I_ADD_10_8_11;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.hazard !== 1'b1) begin
            n_fail++; $display("FAIL rst_stall_pre got=%b exp=1", bus.hazard);
        end
        step();
        n_checks++;
        if (bus.hazard !== 1'b0 || bus.id_ex_ctrl !== 9'h0) begin
            n_fail++; $display("FAIL rst_stall_post got hz=%b ctrl=%b exp 0 0", bus.hazard, bus.id_ex_ctrl);
        end
        reset = 1'b0;
    endtask

    task automatic test_wb_bypass();
        logic [31:0] exp_same;
        drive_idle();
        write_reg(5'd8, 32'h1111_1111);
        bus.instr_in = I_ADD_10_8_11;
        bus.wb_we    = 1'b1;
        bus.wb_addr  = 5'd8;
        bus.wb_data  = 32'hDEADBEEF;
`ifdef WB_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'h1111_1111;
`endif
        step();
        bus.wb_we = 1'b0;
        n_checks++;
        if (bus.id_ex_rs_data !== exp_same) begin
            n_fail++; $display("FAIL wb_same_cycle got=%h exp=%h", bus.id_ex_rs_data, exp_same);
        end
        step();
        n_checks++;
        if (bus.id_ex_rs_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wb_next_cycle got=%h exp=deadbeef", bus.id_ex_rs_data);
        end
    endtask

    task automatic test_zero_reg();
        drive_idle();
        write_reg(5'd0, 32'hFFFF_FFFF);
        // also write $0 in the same cycle the read happens
        bus.instr_in = 32'h00000820;   // add $1,$0,$0
        bus.wb_we    = 1'b1;
        bus.wb_addr  = 5'd0;
        bus.wb_data  = 32'hFFFF_FFFF;
        step();
        bus.wb_we = 1'b0;
        n_checks++;
        if (bus.id_ex_rs_data !== 32'h0 || bus.id_ex_rt_data !== 32'h0) begin
            n_fail++; $display("FAIL zero_same got rs=%h rt=%h exp 0 0", bus.id_ex_rs_data, bus.id_ex_rt_data);
        end
        step();
        n_checks++;
        if (bus.id_ex_rs_data !== 32'h0) begin
            n_fail++; $display("FAIL zero_after got=%h exp=0", bus.id_ex_rs_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instrs [5];
        logic [8:0]  exp_c  [5];
        logic [31:0] exp_i  [5];
        instrs[0] = 32'hFC000000; exp_c[0] = 9'h0;    exp_i[0] = 32'h0000_0000;
        instrs[1] = 32'hAC000010; exp_c[1] = C_SW;    exp_i[1] = 32'h0000_0010;
        instrs[2] = 32'h1000FFFE; exp_c[2] = C_BEQ;   exp_i[2] = 32'hFFFF_FFFE;
        instrs[3] = 32'h2043FFFF; exp_c[3] = C_ADDI;  exp_i[3] = 32'hFFFF_FFFF;
        instrs[4] = 32'h8C008000; exp_c[4] = C_LW;    exp_i[4] = 32'hFFFF_8000;
        drive_idle();
        for (int i = 0; i < 5; i++) begin
            bus.instr_in = instrs[i];
            bus.pc4_in   = 32'h1000 + 32'(i * 4);
            step();
            n_checks++;
            if (bus.id_ex_ctrl !== exp_c[i] || bus.id_ex_imm !== exp_i[i] || bus.id_ex_pc4 !== 32'h1000 + 32'(i * 4)) begin
                n_fail++; $display("FAIL b2b_%0d got ctrl=%b imm=%h pc4=%h exp %b %h %h", i,
                                   bus.id_ex_ctrl, bus.id_ex_imm, bus.id_ex_pc4, exp_c[i], exp_i[i], 32'h1000 + 32'(i * 4));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive_idle();
        test_reset();
        test_add();
        test_load_use();
        test_load_zero();
        test_flush();
        test_reset_mid_stall();
        test_wb_bypass();
        test_zero_reg();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
